// File: rtl/dsp_pkg.sv
// Shared constants and helpers for the DSP48A1 drain logic.
package dsp_pkg;

  localparam int P_WIDTH       = 48;
  localparam int LAT_DEFAULT   = 2;
  localparam int DEPTH_DEFAULT = 4;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/dsp_pipe_drain_if.sv
// Issue / result handshake bundle between the DSP pipeline, the drain block and the consumer.
interface dsp_pipe_drain_if
  import dsp_pkg::*;
#(
  parameter int WIDTH = P_WIDTH,
  parameter int CW    = clog2(DEPTH_DEFAULT) + 1
);

  logic             in_valid;
  logic             in_ready;
  logic             ce;
  logic [WIDTH-1:0] p_in;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [CW-1:0]    count;
  logic [3:0]       inflight;

  modport master (
    output in_valid, p_in, flush, out_ready,
    input  in_ready, ce, out_valid, out_data, count, inflight
  );

  modport slave (
    input  in_valid, p_in, flush, out_ready,
    output in_ready, ce, out_valid, out_data, count, inflight
  );

endinterface

// File: rtl/dsp_drain_fifo.sv
// First-word fall-through result FIFO; full/empty come from the occupancy count only.
module dsp_drain_fifo
  import dsp_pkg::*;
#(
  parameter int WIDTH = P_WIDTH,
  parameter int DEPTH = DEPTH_DEFAULT,
  parameter int CW    = clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_ready_i,
  output logic             out_valid_o,
  output logic [WIDTH-1:0] out_data_o,
  output logic [CW-1:0]    count_o,
  output logic             full_o
);

  localparam int AW = clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             pop;

  assign out_valid_o = (count_q != '0);
  assign full_o      = (count_q == CW'(DEPTH));
  assign pop         = out_valid_o & pop_ready_i;
  assign out_data_o  = out_valid_o ? mem_q[rd_ptr_q] : '0;
  assign count_o     = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_i) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)    rd_ptr_d = rd_ptr_q + AW'(1);
      if (push_i && !pop)      count_d = count_q + CW'(1);
      else if (pop && !push_i) count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: out_data is masked whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push_i && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/dsp_pipe_drain.sv
// Consumer end of the DSP48A1 pipeline: tracks in-flight issues, captures P into a FIFO, stalls via ce.
module dsp_pipe_drain
  import dsp_pkg::*;
#(
  parameter int WIDTH = P_WIDTH,
  parameter int LAT   = LAT_DEFAULT,
  parameter int DEPTH = DEPTH_DEFAULT,
  parameter int CW    = clog2(DEPTH) + 1
) (
  input logic             clk,
  input logic             rst,
  dsp_pipe_drain_if.slave bus
);

  logic full;
  logic ce;
  logic head_valid;
  logic push;

  // ce depends on registered occupancy only, so out_ready never reaches the DSP enables combinationally.
  assign ce           = ~full;
  assign bus.ce       = ce;
  assign bus.in_ready = ce;
  assign push         = ce & head_valid;

  generate
    if (LAT == 0) begin : g_comb
      assign head_valid   = bus.in_valid;
      assign bus.inflight = '0;
    end else begin : g_vsr
      logic [LAT-1:0] vsr_q, vsr_d;

      always_comb begin
        vsr_d = vsr_q;
        if (bus.flush)
          vsr_d = '0;
        else if (ce)
          vsr_d = LAT'({vsr_q, bus.in_valid});
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) vsr_q <= '0;
        else     vsr_q <= vsr_d;
      end

      assign head_valid   = vsr_q[LAT-1];
      assign bus.inflight = 4'($countones(vsr_q));
    end
  endgenerate

  dsp_drain_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .flush_i     (bus.flush),
    .push_i      (push),
    .wdata_i     (bus.p_in),
    .pop_ready_i (bus.out_ready),
    .out_valid_o (bus.out_valid),
    .out_data_o  (bus.out_data),
    .count_o     (bus.count),
    .full_o      (full)
  );

endmodule

// File: tb/tb_dsp_pipe_drain.sv
// Scoreboard bench for dsp_pipe_drain: a LAT=2 and a LAT=0 instance share one randomized stimulus stream.
module tb_dsp_pipe_drain;
  import dsp_pkg::*;

  localparam int W   = 48;
  localparam int L2  = 2;
  localparam int D   = 4;
  localparam int CWL = 3;

  logic         clk = 1'b0;
  logic         rst;
  logic         iv, ordy, fl;
  logic [W-1:0] op;
  int           checks = 0;
  int           errors = 0;

  always #5 clk = ~clk;

  dsp_pipe_drain_if #(.WIDTH(W), .CW(CWL)) b2();
  dsp_pipe_drain_if #(.WIDTH(W), .CW(CWL)) b0();

  // Behavioural DSP48A1 register stages for the LAT=2 instance, frozen by its ce.
  logic [W-1:0] dsp_s0 = '0;
  logic [W-1:0] dsp_s1 = '0;
  always @(posedge clk) begin
    if (b2.ce) begin
      dsp_s0 <= op;
      dsp_s1 <= dsp_s0;
    end
  end

  assign b2.in_valid  = iv;
  assign b2.flush     = fl;
  assign b2.out_ready = ordy;
  assign b2.p_in      = dsp_s1;
  assign b0.in_valid  = iv;
  assign b0.flush     = fl;
  assign b0.out_ready = ordy;
  assign b0.p_in      = op;

  dsp_pipe_drain #(.WIDTH(W), .LAT(L2), .DEPTH(D), .CW(CWL)) u_dut2 (
    .clk (clk),
    .rst (rst),
    .bus (b2)
  );

  dsp_pipe_drain #(.WIDTH(W), .LAT(0), .DEPTH(D), .CW(CWL)) u_dut0 (
    .clk (clk),
    .rst (rst),
    .bus (b0)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: each accepted issue waits LAT enabled cycles, then joins the FIFO.
  int           pipe2_q[$];
  int           fifo2_n = 0;
  logic [W-1:0] sb2_q[$];
  int           fifo0_n = 0;
  logic [W-1:0] sb0_q[$];
  bit           ce2_m, pop2_m, ce0_m, pop0_m;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      pipe2_q.delete();
      sb2_q.delete();
      fifo2_n = 0;
    end else if (fl) begin
      pipe2_q.delete();
      sb2_q.delete();
      fifo2_n = 0;
    end else begin
      if (b2.out_valid && b2.out_ready) begin
        if (sb2_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL l2_unexpected_pop: got data 0x%0h expected no output at %0t", b2.out_data, $time);
        end else begin
          chk("l2_data", 64'(b2.out_data), 64'(sb2_q.pop_front()));
        end
      end
      ce2_m  = (fifo2_n != D);
      pop2_m = (fifo2_n != 0) && ordy;
      if (ce2_m) begin
        foreach (pipe2_q[i]) pipe2_q[i]--;
        if (pipe2_q.size() > 0 && pipe2_q[0] == 0) begin
          void'(pipe2_q.pop_front());
          fifo2_n++;
        end
        if (iv) begin
          pipe2_q.push_back(L2);
          sb2_q.push_back(op);
        end
      end
      if (pop2_m) fifo2_n--;
    end
  end

  always @(posedge clk or posedge rst) begin
    if (rst || fl) begin
      sb0_q.delete();
      fifo0_n = 0;
    end else begin
      if (b0.out_valid && b0.out_ready) begin
        if (sb0_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL l0_unexpected_pop: got data 0x%0h expected no output at %0t", b0.out_data, $time);
        end else begin
          chk("l0_data", 64'(b0.out_data), 64'(sb0_q.pop_front()));
        end
      end
      ce0_m  = (fifo0_n != D);
      pop0_m = (fifo0_n != 0) && ordy;
      if (ce0_m && iv) begin
        fifo0_n++;
        sb0_q.push_back(op);
      end
      if (pop0_m) fifo0_n--;
    end
  end

  always @(negedge clk) begin
    chk("l2_count",    64'(b2.count),     64'(fifo2_n));
    chk("l2_valid",    64'(b2.out_valid), 64'(fifo2_n != 0));
    chk("l2_ce",       64'(b2.ce),        64'(fifo2_n != D));
    chk("l2_in_ready", 64'(b2.in_ready),  64'(fifo2_n != D));
    chk("l2_inflight", 64'(b2.inflight),  64'(pipe2_q.size()));
    if (fifo2_n != 0) begin
      if (sb2_q.size() != 0) chk("l2_head", 64'(b2.out_data), 64'(sb2_q[0]));
      else chk("l2_sb_underrun", 64'(sb2_q.size()), 64'(fifo2_n));
    end else begin
      chk("l2_zero_data", 64'(b2.out_data), 64'(0));
    end
    chk("l0_count", 64'(b0.count),     64'(fifo0_n));
    chk("l0_valid", 64'(b0.out_valid), 64'(fifo0_n != 0));
    chk("l0_ce",    64'(b0.ce),        64'(fifo0_n != D));
    if (fifo0_n == 0) chk("l0_zero_data", 64'(b0.out_data), 64'(0));
  end

  task automatic step(input logic v, input logic [W-1:0] d, input logic r, input logic f);
    @(posedge clk);
    #1;
    iv   = v;
    op   = d;
    ordy = r;
    fl   = f;
  endtask

  initial begin
    rst  = 1'b1;
    iv   = 1'b0;
    ordy = 1'b0;
    fl   = 1'b0;
    op   = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_ce",       64'(b2.ce),        64'(1));
    chk("rst_out_data", 64'(b2.out_data),  64'(0));
    chk("rst_count",    64'(b2.count),     64'(0));

    // Back-to-back issues with a ready consumer
    for (int i = 0; i < 8; i++) step(1'b1, W'(16 + i), 1'b1, 1'b0);
    repeat (6) step(1'b0, '0, 1'b1, 1'b0);

    // Fill to full with consumer stalled, then release
    for (int i = 0; i < 8; i++) step(1'b1, W'(32 + i), 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    chk("full_count",    64'(b2.count),    64'(4));
    chk("full_ce",       64'(b2.ce),       64'(0));
    chk("full_inflight", 64'(b2.inflight), 64'(2));
    repeat (10) step(1'b0, '0, 1'b1, 1'b0);

    // Steady push+pop at count 2 across pointer wrap
    for (int i = 0; i < 12; i++) step(1'b1, W'(64 + i), i >= 4, 1'b0);
    chk("pp_count", 64'(b2.count), 64'(2));
    repeat (8) step(1'b0, '0, 1'b1, 1'b0);

    // LAT=0 pass-through
    step(1'b0, '0, 1'b1, 1'b1);
    step(1'b1, W'(48'hABC), 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    chk("l0_next_valid", 64'(b0.out_valid), 64'(1));
    chk("l0_next_data",  64'(b0.out_data),  64'(48'hABC));
    repeat (6) step(1'b0, '0, 1'b1, 1'b0);

    // Flush with stored and in-flight results
    for (int i = 0; i < 5; i++) step(1'b1, W'(96 + i), 1'b0, 1'b0);
    step(1'b1, W'(200), 1'b1, 1'b1);
    chk("pre_flush_count",    64'(b2.count),    64'(3));
    chk("pre_flush_inflight", 64'(b2.inflight), 64'(2));
    step(1'b0, '0, 1'b1, 1'b0);
    chk("flush_count",    64'(b2.count),     64'(0));
    chk("flush_valid",    64'(b2.out_valid), 64'(0));
    chk("flush_data",     64'(b2.out_data),  64'(0));
    chk("flush_inflight", 64'(b2.inflight),  64'(0));

    // Randomized traffic with varying back-pressure
    for (int i = 0; i < 500; i++) begin
      step($urandom_range(0, 3) != 0,
           W'({$urandom(), $urandom()}),
           $urandom_range(0, 9) < (2 + (i / 50) % 8),
           $urandom_range(0, 59) == 0);
    end
    repeat (12) step(1'b0, '0, 1'b1, 1'b0);

    // Async reset in the middle of a burst
    for (int i = 0; i < 5; i++) step(1'b1, W'(300 + i), 1'b0, 1'b0);
    #3;
    rst = 1'b1;
    iv  = 1'b0;
    #1;
    chk("arst_count",    64'(b2.count),     64'(0));
    chk("arst_valid",    64'(b2.out_valid), 64'(0));
    chk("arst_data",     64'(b2.out_data),  64'(0));
    chk("arst_ce",       64'(b2.ce),        64'(1));
    chk("arst_inflight", 64'(b2.inflight),  64'(0));
    chk("arst_l0_count", 64'(b0.count),     64'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    step(1'b1, W'(48'h5A5), 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    chk("arst_lat_early", 64'(b2.out_valid), 64'(0));
    step(1'b0, '0, 1'b1, 1'b0);
    chk("arst_lat_valid", 64'(b2.out_valid), 64'(1));
    chk("arst_lat_data",  64'(b2.out_data),  64'(48'h5A5));
    repeat (8) step(1'b0, '0, 1'b1, 1'b0);

    chk("l2_drained", 64'(sb2_q.size()), 64'(0));
    chk("l0_drained", 64'(sb0_q.size()), 64'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dsp_pipe_drain.md
Name: dsp_pipe_drain

Overview:
- Consumer end of the DSP48A1 register pipeline.
- Tracks which operand issues are in flight through LAT enabled register stages and captures each matching P result into a DEPTH-entry FIFO.
- Presents results downstream on a valid/ready handshake.
- Drives the pipeline clock-enable (ce) so the DSP stages freeze, not drop results, when the FIFO is full.

Parameters:
- WIDTH, 48, result width (P bus).
- LAT, 2, number of registered stages between operand issue and P (0..8; 0 = fully combinational path).
- DEPTH, 4, FIFO entries; power of two, >= 2.
- CW, $clog2(DEPTH)+1, occupancy counter width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  operand set presented to DSP this cycle.
- in_ready  out  1  issue accepted when in_valid & in_ready; equals ce.
- ce  out  1  global enable to every DSP pipeline register stage.
- p_in  in  WIDTH  DSP P output.
- flush  in  1  synchronous clear of tracker and FIFO.
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  downstream accept.
- out_data  out  WIDTH  FIFO head; forced 0 when out_valid=0.
- count  out  CW  FIFO occupancy.
- inflight  out  4  number of set bits in the valid tracker.

Behaviour:
- Reset (async):
  - Valid tracker, FIFO pointers and count cleared.
  - out_valid=0, out_data=0, count=0, inflight=0.
  - ce=in_ready=1.
- ce = ~full, where full = (count==DEPTH). Registered-state decode only; there is no combinational path from out_ready to ce.
- Valid tracker: LAT-bit shift register vsr.
  - On ce=1: vsr <= {vsr[LAT-2:0], in_valid}.
  - On ce=0: vsr holds, matching the frozen DSP stages.
- head_valid = vsr[LAT-1]; for LAT=0, head_valid = in_valid.
- push = ce & head_valid. Writes p_in to mem[wr_ptr]; wr_ptr++ (wraps mod DEPTH).
- pop = out_valid & out_ready. rd_ptr++ (wraps mod DEPTH).
- count: +1 on push only, -1 on pop only, unchanged on simultaneous push and pop.
- FIFO behaviour is first-word fall-through: out_valid = (count!=0); out_data = mem[rd_ptr].
- Latency: an issue accepted at cycle t with ce held high is visible on out_valid at t+LAT+1 (one cycle of FIFO write).
- Full case:
  - ce=0. No issue is accepted and no push occurs.
  - A pop in the same cycle makes ce=1 on the next cycle. This costs one bubble.
- Empty case: a pop is impossible (out_valid=0). A push into an empty FIFO appears the next cycle.
- Wrap-around: pointers are log2(DEPTH) bits and wrap naturally. Full and empty are decided by count, never by pointer compare.
- flush:
  - Next edge: vsr=0, pointers=0, count=0.
  - Overrides push and pop in the same cycle.
  - ce is unaffected other than via count.
- Reset mid-stream: all in-flight and stored results are discarded. The DSP registers are reset by their own rst.
- in_valid while in_ready=0: not an issue; the source must hold it.

Decomposition:
- Shared package dsp_pkg holds:
  - P_WIDTH=48.
  - Default pipeline LAT constant.
  - Function clog2.
- Natural sub-module: dsp_drain_fifo (mem, pointers, count, FWFT head). The parent holds the valid tracker and ce logic.

Test Plan:
- LAT=2, DEPTH=4, out_ready=1, issue 8 back-to-back with P = 0x10..0x17 -> out_valid from cycle 3, data 0x10..0x17 in order, ce stays 1, count <= 1.
- out_ready=0, issue continuously -> after 4 pushes count=4, ce=0, vsr frozen with inflight=2. Then out_ready=1 -> ce=1 one cycle after first pop, no result lost or duplicated across 6 issues.
- Simultaneous push and pop at count=2 -> count remains 2, data order preserved across wrap (wr_ptr 3->0).
- LAT=0 -> in_valid with p_in=0xABC gives out_valid next cycle with out_data=0xABC.
- flush with count=3, inflight=2, out_ready=1 -> next cycle count=0, out_valid=0, out_data=0, no pop counted, inflight=0.
- Async rst asserted mid-burst between clock edges -> outputs clear immediately, ce=1. After release, a fresh issue returns correctly at LAT+1.
